// File: rtl/port_io_expander.sv
// Remote end of the slot-multiplexed port I/O bus: per-port dir/out registers drive the pins,
// and synchronized pin levels are returned to the host in each port's read slot.
module port_io_expander #(
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   port_rst,
  inout  wire  [7:0]             data,
  inout  wire  [8*NUM_PORTS-1:0] pins,
  output logic                   linked,
  output logic                   sync_err
);
  localparam int FRAME_LEN = 1 + 3*NUM_PORTS;
  localparam int SW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] LAST = SW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [SW-1:0]                slot;
  logic [CW-1:0]                idle_cnt;
  logic [CW-1:0]                idle_nxt;
  logic [NUM_PORTS-1:0][7:0]    dir_q;
  logic [NUM_PORTS-1:0][7:0]    out_q;
  logic [NUM_PORTS-1:0][7:0]    sync1;
  logic [NUM_PORTS-1:0][7:0]    sync2;
  logic [NUM_PORTS-1:0]         dir_hit;
  logic [NUM_PORTS-1:0]         wr_hit;
  logic                         rd_oe;
  logic [7:0]                   rd_val;

  // Slot decode looks only at the registered slot, so port_rst never reaches the data enable.
  always_comb begin
    dir_hit = '0;
    wr_hit  = '0;
    rd_oe   = 1'b0;
    rd_val  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dir_hit[p] = (slot == SW'(3*p + 1));
      wr_hit[p]  = (slot == SW'(3*p + 3));
      if (slot == SW'(3*p + 2)) begin
        rd_oe  = 1'b1;
        rd_val = sync2[p];
      end
    end
  end

  assign idle_nxt = (idle_cnt == TMAX) ? idle_cnt : idle_cnt + 1'b1;

  assign data = rd_oe ? rd_val : 8'hzz;

  for (genvar i = 0; i < 8*NUM_PORTS; i++) begin : g_pin
    assign pins[i] = dir_q[i/8][i%8] ? out_q[i/8][i%8] : 1'bz;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot     <= '0;
      idle_cnt <= '0;
      dir_q    <= '0;
      out_q    <= '0;
      sync1    <= '0;
      sync2    <= '0;
      linked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync1    <= pins;
      sync2    <= sync1;
      sync_err <= 1'b0;
      if (port_rst) begin
        // A sync always restarts the frame; the interrupted slot latches nothing.
        slot     <= SW'(1);
        idle_cnt <= '0;
        if (slot != '0) begin
          sync_err <= 1'b1;
          linked   <= 1'b0;
        end
      end else if (slot != '0) begin
        idle_cnt <= '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (dir_hit[p]) dir_q[p] <= data;
          if (wr_hit[p])  out_q[p] <= data;
        end
        if (slot == LAST) begin
          slot   <= '0;
          linked <= 1'b1;
        end else begin
          slot <= slot + 1'b1;
        end
      end else begin
        idle_cnt <= idle_nxt;
        // Link lost: release every pin but keep the output values for the next frame.
        if (idle_nxt == TMAX) begin
          linked <= 1'b0;
          dir_q  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_port_io_expander.sv
// Randomized bench for port_io_expander with a slot-level reference model of the host protocol.
module tb_port_io_expander;
  localparam int NP = 3;
  localparam int TO = 16;
  localparam int FL = 1 + 3*NP;
  localparam int PW = 8*NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          port_rst = 1'b0;
  wire  [7:0]    data;
  wire  [PW-1:0] pins;
  logic          linked;
  logic          sync_err;

  logic          host_en = 1'b0;
  logic [7:0]    host_val = '0;
  logic [PW-1:0] pen = '0;
  logic [PW-1:0] pval = '0;

  always #5 clk = ~clk;

  assign data = host_en ? host_val : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_dpu
    pullup (data[g]);
  end
  for (genvar g = 0; g < PW; g++) begin : g_pdrv
    assign pins[g] = pen[g] ? pval[g] : 1'bz;
    pullup (pins[g]);
  end

  port_io_expander #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .port_rst (port_rst),
    .data     (data),
    .pins     (pins),
    .linked   (linked),
    .sync_err (sync_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: protocol-level view of the remote registers and link state.
  int            mslot, midle;
  bit            mlinked, merr;
  logic [7:0]    mdir [NP];
  logic [7:0]    mout [NP];
  logic [PW-1:0] hist [$];
  bit            prel, pfix;
  logic [PW-1:0] pfixval;
  logic [7:0]    fv [FL];
  logic [7:0]    last_data, rd_log [NP];
  logic [PW-1:0] last_pins;
  bit            last_linked, last_err;

  task automatic model_reset();
    mslot = 0; midle = 0; mlinked = 0; merr = 0;
    for (int p = 0; p < NP; p++) begin mdir[p] = '0; mout[p] = '0; end
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
  endtask

  // Level seen on each pin: our own driven output, else the external driver, else the pullup.
  function automatic logic [PW-1:0] pin_level();
    logic [PW-1:0] l;
    for (int i = 0; i < PW; i++)
      l[i] = mdir[i/8][i%8] ? mout[i/8][i%8] : (pen[i] ? pval[i] : 1'b1);
    return l;
  endfunction

  task automatic cycle(input bit s, input bit hen, input logic [7:0] hv);
    int rp, k;
    logic [PW-1:0] lvl, old;
    logic [7:0] bus;
    rp = -1;
    if (mslot != 0 && (mslot - 1) % 3 == 1) rp = (mslot - 1) / 3;
    port_rst = s;
    host_en  = hen && (rp < 0);
    host_val = hv;
    for (int i = 0; i < PW; i++) pen[i] = !prel && !mdir[i/8][i%8];
    pval = pfix ? pfixval : PW'($urandom());
    lvl = pin_level();
    hist.push_back(lvl);
    old = hist[hist.size() - 3];
    if (rp >= 0)      bus = old[rp*8 +: 8];
    else if (host_en) bus = hv;
    else              bus = 8'hFF;
    @(negedge clk);
    last_data = data; last_pins = pins; last_linked = linked; last_err = sync_err;
    if (rp >= 0) rd_log[rp] = data;
    chk("data", 32'(data), 32'(bus));
    chk("pins", 32'(pins), 32'(lvl));
    chk("linked", 32'(linked), 32'(mlinked));
    chk("sync_err", 32'(sync_err), 32'(merr));
    @(posedge clk);
    merr = 0;
    if (s) begin
      if (mslot != 0) begin merr = 1; mlinked = 0; end
      mslot = 1; midle = 0;
    end else if (mslot != 0) begin
      k = (mslot - 1) % 3;
      if (k == 0) mdir[(mslot - 1) / 3] = bus;
      if (k == 2) mout[(mslot - 1) / 3] = bus;
      midle = 0;
      if (mslot == FL - 1) begin mslot = 0; mlinked = 1; end
      else mslot++;
    end else begin
      if (midle < TO) midle++;
      if (midle == TO) begin
        mlinked = 0;
        for (int p = 0; p < NP; p++) mdir[p] = '0;
      end
    end
    #1;
  endtask

  task automatic run_frame(input bit do_sync, input int cut);
    if (do_sync) cycle(1'b1, 1'b0, 8'h00);
    for (int s = 1; s < FL; s++) begin
      if (s == cut) begin
        cycle(1'b1, 1'b0, 8'h00);
        return;
      end
      cycle(1'b0, 1'b1, fv[s]);
    end
  endtask

  initial begin
    int cut, gap;
    rst = 1'b0;
    prel = 1; pfix = 0; pfixval = '0;
    model_reset();
    for (int i = 0; i < NP; i++) rd_log[i] = '0;
    repeat (4) begin
      port_rst = 1'($urandom());
      @(negedge clk);
      chk("rst_data", 32'(data), 32'hFF);
      chk("rst_pins", 32'(pins), 32'({PW{1'b1}}));
      chk("rst_linked", 32'(linked), 32'd0);
      chk("rst_err", 32'(sync_err), 32'd0);
      @(posedge clk); #1;
    end
    port_rst = 1'b0;
    rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    // Directed full frame with port0 upper nibble held at 0xA.
    prel = 0; pfix = 1; pfixval = 24'h3CC3A0;
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h0F);
    cycle(1'b0, 1'b0, 8'h00);
    chk("rd_p0", 32'(last_data), 32'hA0);
    cycle(1'b0, 1'b1, 8'h05);
    cycle(1'b0, 1'b1, 8'h00);
    chk("pins_lo", 32'(last_pins[3:0]), 32'h5);
    for (int s = 5; s < FL; s++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    chk("linked_up", 32'(last_linked), 32'd1);

    // Sync in slot 4 interrupts the frame; dir1 must not take 0x55.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h0F);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h06);
    cycle(1'b1, 1'b1, 8'h55);
    cycle(1'b0, 1'b1, 8'h0F);
    chk("cut_err", 32'(last_err), 32'd1);
    chk("cut_linked", 32'(last_linked), 32'd0);
    for (int s = 2; s < FL; s++) cycle(1'b0, 1'b1, (s == 3) ? 8'h05 : 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    chk("cut_err_once", 32'(last_err), 32'd0);

    // Back-to-back frames.
    for (int s = 0; s < FL; s++) fv[s] = 8'h00;
    fv[1] = 8'h0F; fv[3] = 8'h05; fv[4] = 8'hF0; fv[6] = 8'h90;
    repeat (3) run_frame(1'b1, 0);
    cycle(1'b0, 1'b0, 8'h00);
    chk("b2b_linked", 32'(last_linked), 32'd1);

    // Watchdog: pins released externally so any remaining drive would show.
    prel = 1;
    repeat (TO) cycle(1'b0, 1'b0, 8'h00);
    chk("wd_linked", 32'(last_linked), 32'd0);
    chk("wd_pins", 32'(last_pins), 32'({PW{1'b1}}));
    prel = 0;
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h33);
    chk("wd_retained", 32'(last_pins[7:0]), 32'h05);
    for (int s = 4; s < FL; s++) cycle(1'b0, 1'b1, fv[s]);

    // Async reset in slot 5 (port1 read slot).
    run_frame(1'b1, 5);
    for (int s = 1; s < 5; s++) cycle(1'b0, 1'b1, (s == 1) ? 8'hFF : 8'h00);
    port_rst = 1'b0; host_en = 1'b0;
    #2;
    rst = 1'b0;
    pen = '0;
    #1;
    chk("arst_data", 32'(data), 32'hFF);
    chk("arst_pins", 32'(pins), 32'({PW{1'b1}}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    pfixval = {PW{1'b1}};
    fv[1] = 8'hFF;
    run_frame(1'b1, 3);
    run_frame(1'b0, 0);
    chk("arst_out0", 32'(rd_log[0]), 32'h00);

    // Randomized frames, cuts, gaps and idle bus traffic.
    pfix = 0;
    repeat (40) begin
      for (int s = 0; s < FL; s++) fv[s] = 8'($urandom());
      cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, FL - 1) : 0;
      run_frame(1'b1, cut);
      if (cut != 0) run_frame(1'b0, 0);
      prel = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 20);
      repeat (gap) cycle(1'b0, 1'($urandom()), 8'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
